soc_bram_arb: RTL and testbench

//  Arbitrates two requesters (p0: CPU bus, p1: USB/DMA engine) onto one single-port
//  32-bit SoC BRAM with 1-cycle synchronous read latency and active-low byte write mask.

---
 rtl/soc_bram_arb.sv | 131 +++++++++++++
 tb/tb_soc_bram_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bram_arb.sv
// Two-port round-robin arbiter in front of a single-port 1-cycle-latency BRAM.
// Latency: req sampled in IDLE -> ack two cycles later; at most one access per 3 cycles.
// Backpressure: requesters hold req until their ack; SOC_BRAM_ARB_LOCK_EN adds p0_lock/p1_lock.
module soc_bram_arb #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  input  logic [3:0]    p0_wmsk,
  input  logic          p0_we,
  output logic          p0_ack,
  output logic [31:0]   p0_rdata,
  input  logic          p1_req,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  input  logic [3:0]    p1_wmsk,
  input  logic          p1_we,
  output logic          p1_ack,
  output logic [31:0]   p1_rdata,
`ifdef SOC_BRAM_ARB_LOCK_EN
  input  logic          p0_lock,
  input  logic          p1_lock,
`endif
  output logic [AW-1:0] bram_addr,
  output logic [31:0]   bram_wdata,
  output logic [3:0]    bram_wmsk,
  output logic          bram_we,
  input  logic [31:0]   bram_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   grant_q, grant_d;   // 0 = p0, 1 = p1
  logic   last_q,  last_d;    // port granted most recently
  logic   ack0_q,  ack0_d;
  logic   ack1_q,  ack1_d;

  logic   any_req;
  logic   pick;

  // Arbitration decision: single requester wins, a tie goes to the port not served last.
  // A locked last-served port keeps exclusive access until it drops its lock.
  always_comb begin
    any_req = 1'b0;
    pick    = last_q;
`ifdef SOC_BRAM_ARB_LOCK_EN
    if (last_q ? p1_lock : p0_lock) begin
      any_req = last_q ? p1_req : p0_req;
      pick    = last_q;
    end else begin
      any_req = p0_req | p1_req;
      pick    = (p0_req & p1_req) ? ~last_q : p1_req;
    end
`else
    any_req = p0_req | p1_req;
    pick    = (p0_req & p1_req) ? ~last_q : p1_req;
`endif
  end

  // Next-state logic for the IDLE -> ISSUE -> RESP sequencer.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          last_d  = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // BRAM samples the address at the end of ISSUE, data is back during RESP
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; last resets to p1 so p0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
    end
  end

  // BRAM side follows the grant mux at all times; write enable only while issuing.
  always_comb begin
    bram_addr  = grant_q ? p1_addr  : p0_addr;
    bram_wdata = grant_q ? p1_wdata : p0_wdata;
    bram_wmsk  = grant_q ? p1_wmsk  : p0_wmsk;
    bram_we    = (state_q == ISSUE) & (grant_q ? p1_we : p0_we);
  end

  // Requester side: one-cycle ack pulse, read data gated to zero outside the ack.
  always_comb begin
    p0_ack   = ack0_q;
    p1_ack   = ack1_q;
    p0_rdata = ack0_q ? bram_rdata : 32'h0;
    p1_rdata = ack1_q ? bram_rdata : 32'h0;
  end

endmodule

// File: tb/tb_soc_bram_arb.sv
// Randomized scoreboard bench for soc_bram_arb with a behavioural BRAM and reference memory.
// Expected grant order, ack cycle and read data are pushed per access; a monitor checks acks.
// Define SOC_BRAM_ARB_LOCK_EN for both files to exercise the lock inputs.
module tb_soc_bram_arb;

  localparam int AW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wmsk;
    logic          we;
  } acc_t;

  typedef struct {
    bit          port;
    bit          chk;
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req, p1_req;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [31:0]   p0_wdata, p1_wdata;
  logic [3:0]    p0_wmsk, p1_wmsk;
  logic          p0_we, p1_we;
  logic          p0_ack, p1_ack;
  logic [31:0]   p0_rdata, p1_rdata;
`ifdef SOC_BRAM_ARB_LOCK_EN
  logic          p0_lock, p1_lock;
`endif
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wdata;
  logic [3:0]    bram_wmsk;
  logic          bram_we;
  logic [31:0]   bram_rdata;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic [31:0] mem [2**AW];
  logic [31:0] ref_mem [2**AW];
  bit          ref_valid [2**AW];
  bit          m_last;

  soc_bram_arb #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmsk(p0_wmsk),
    .p0_we(p0_we), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmsk(p1_wmsk),
    .p1_we(p1_we), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
`ifdef SOC_BRAM_ARB_LOCK_EN
    .p0_lock(p0_lock), .p1_lock(p1_lock),
`endif
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_wmsk(bram_wmsk),
    .bram_we(bram_we), .bram_rdata(bram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port BRAM: read-before-write, 1-cycle read latency, active-low byte mask.
  always @(posedge clk) begin
    if (bram_we) begin
      for (int b = 0; b < 4; b++)
        if (!bram_wmsk[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
    end
    bram_rdata <= mem[bram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference memory: accesses take effect in grant order; read data is checked only
  // when every byte of the word has a known value.
  function automatic exp_t model_access(input bit port, input acc_t a, input int c);
    exp_t e;
    e.port = port;
    e.cyc  = c;
    e.chk  = !a.we && ref_valid[a.addr];
    e.dat  = ref_mem[a.addr];
    if (a.we) begin
      for (int b = 0; b < 4; b++)
        if (!a.wmsk[b]) ref_mem[a.addr][8*b +: 8] = a.wdata[8*b +: 8];
      if (a.wmsk == 4'b0000) ref_valid[a.addr] = 1'b1;
    end
    return e;
  endfunction

  task automatic drive(input bit port, input bit req, input acc_t a);
    if (port) begin
      p1_req = req; p1_addr = a.addr; p1_wdata = a.wdata; p1_wmsk = a.wmsk; p1_we = a.we;
    end else begin
      p0_req = req; p0_addr = a.addr; p0_wdata = a.wdata; p0_wmsk = a.wmsk; p0_we = a.we;
    end
  endtask

  // Wait for acks on the flagged ports, dropping each request at its ack.
  task automatic wait_acks(input bit w0, input bit w1, input string name);
    bit pend0, pend1;
    pend0 = w0;
    pend1 = w1;
    for (int k = 0; k < 20 && (pend0 || pend1); k++) begin
      @(negedge clk);
      if (pend0 && p0_ack) begin p0_req = 1'b0; pend0 = 1'b0; end
      if (pend1 && p1_ack) begin p1_req = 1'b0; pend1 = 1'b0; end
    end
    if (pend0 || pend1) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: pending p0=%0b p1=%0b, required both acked", name, pend0, pend1);
      p0_req = 1'b0;
      p1_req = 1'b0;
    end
  endtask

  // One arbitration round starting in an IDLE cycle: winner acks at +2, loser at +5.
  task automatic do_round(input bit r0, input bit r1, input acc_t a0, input acc_t a1, input int gap);
    bit   w;
    int   c;
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1;
    c = cyc;
    w = (r0 && r1) ? !m_last : r1;
    sb.push_back(model_access(w, w ? a1 : a0, c + 2));
    m_last = w;
    if (r0 && r1) begin
      sb.push_back(model_access(!w, w ? a0 : a1, c + 5));
      m_last = !w;
    end
    drive(1'b0, r0, a0);
    drive(1'b1, r1, a1);
    wait_acks(r0, r1, "round");
  endtask

  function automatic acc_t rand_acc();
    acc_t a;
    a.addr  = AW'($urandom_range(0, 15));
    a.wdata = $urandom;
    a.wmsk  = 4'($urandom);
    a.we    = 1'($urandom);
    return a;
  endfunction

  // Monitor: every ack is popped against the scoreboard; never both acks at once.
  initial begin
    exp_t e;
    bit   port;
    forever begin
      @(negedge clk);
      if (rst_n && (p0_ack || p1_ack)) begin
        if (p0_ack && p1_ack) begin
          n_cmp++;
          n_err++;
          $display("FAIL dual_ack: both acks high at cycle %0d, required at most one", cyc);
        end else if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_ack: p0=%0b p1=%0b at cycle %0d, required no ack", p0_ack, p1_ack, cyc);
        end else begin
          e = sb.pop_front();
          port = p1_ack;
          chk("ack_port", {31'b0, port}, {31'b0, e.port});
          chk("ack_cycle", 32'(cyc), 32'(e.cyc));
          if (e.chk) chk("rdata", port ? p1_rdata : p0_rdata, e.dat);
          chk("other_rdata_zero", port ? p0_rdata : p1_rdata, 32'h0);
        end
      end
    end
  end

  // Global bound so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    acc_t a0, a1, nil;
    int   c;
    bit   r0, r1;
    int   seen;
    nil = '0;
    for (int i = 0; i < 2**AW; i++) begin
      ref_mem[i]   = 32'h0;
      ref_valid[i] = 1'b0;
    end
    m_last = 1'b1;
    rst_n  = 1'b0;
    drive(1'b0, 1'b0, nil);
    drive(1'b1, 1'b0, nil);
`ifdef SOC_BRAM_ARB_LOCK_EN
    p0_lock = 1'b0;
    p1_lock = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: nothing moves for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_p0_ack", {31'b0, p0_ack}, 32'h0);
      chk("rst_p1_ack", {31'b0, p1_ack}, 32'h0);
      chk("rst_bram_we", {31'b0, bram_we}, 32'h0);
      chk("rst_p0_rdata", p0_rdata, 32'h0);
    end

    // Directed write/read and masked partial write.
    do_round(1, 0, '{addr: 8'h12, wdata: 32'hA5A5A5A5, wmsk: 4'b0000, we: 1'b1}, nil, 0);
    do_round(1, 0, '{addr: 8'h12, wdata: 32'h0, wmsk: 4'hF, we: 1'b0}, nil, 0);
    do_round(0, 1, nil, '{addr: 8'h12, wdata: 32'h11223344, wmsk: 4'b1110, we: 1'b1}, 1);
    do_round(0, 1, nil, '{addr: 8'h12, wdata: 32'h0, wmsk: 4'hF, we: 1'b0}, 0);

    // Continuous contention: alternating grants, acks three cycles apart.
    for (int i = 0; i < 3; i++) do_round(1, 1, rand_acc(), rand_acc(), 0);

    // Reset while an access sits in ISSUE: no ack, outputs back to reset values.
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, '{addr: 8'h12, wdata: 32'h0, wmsk: 4'hF, we: 1'b0});
    @(posedge clk);
    #1 rst_n = 1'b0;
    m_last = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("midrst_p0_ack", {31'b0, p0_ack}, 32'h0);
      chk("midrst_p1_ack", {31'b0, p1_ack}, 32'h0);
      chk("midrst_bram_we", {31'b0, bram_we}, 32'h0);
      chk("midrst_p0_rdata", p0_rdata, 32'h0);
      chk("midrst_p1_rdata", p1_rdata, 32'h0);
    end
    p0_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    // First tie after reset must go to p0 again.
    do_round(1, 1, rand_acc(), rand_acc(), 0);

`ifdef SOC_BRAM_ARB_LOCK_EN
    // Locked p1 is served twice while p0 waits; releasing the lock lets p0 in.
    do_round(0, 1, nil, rand_acc(), 0);
    @(posedge clk);
    #1;
    c  = cyc;
    a0 = '{addr: 8'h12, wdata: 32'h0, wmsk: 4'hF, we: 1'b0};
    a1 = '{addr: 8'h12, wdata: 32'h0, wmsk: 4'hF, we: 1'b0};
    sb.push_back(model_access(1'b1, a1, c + 2));
    sb.push_back(model_access(1'b1, a1, c + 5));
    sb.push_back(model_access(1'b0, a0, c + 8));
    m_last  = 1'b0;
    p1_lock = 1'b1;
    drive(1'b0, 1'b1, a0);
    drive(1'b1, 1'b1, a1);
    seen = 0;
    for (int k = 0; k < 20 && seen < 2; k++) begin
      @(negedge clk);
      if (p1_ack) seen++;
    end
    p1_req  = 1'b0;
    p1_lock = 1'b0;
    chk("lock_p1_acks", 32'(seen), 32'd2);
    wait_acks(1'b1, 1'b0, "lock_p0");
`endif

    // Randomized traffic with random idle gaps.
    for (int i = 0; i < 150; i++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      a0 = rand_acc();
      a1 = rand_acc();
      do_round(r0, r1, a0, a1, $urandom_range(0, 2));
    end

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
